de2_115_sysid_checker: RTL
==========================

DE2_115_SYSID_CHECKER -- requirements
Module: de2_115_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0, the value required at sysid word address 0.
REQ-002 Parameter EXPECTED_TS, default 1523842120, the value required at sysid word address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, the maximum consecutive waitrequest cycles tolerated per read (range 1..65535).
REQ-004 clock  input  1  the single block clock; all logic is rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a check; honoured only in IDLE.
REQ-007 avm_address  output  1  word address to the sysid slave.
REQ-008 avm_read  output  1  Avalon-MM read strobe.
REQ-009 avm_waitrequest  input  1  slave stall; a transfer completes on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-010 avm_readdata  input  32  read data, valid on the completing cycle (zero read latency).
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle pulse when a check finishes.
REQ-013 id_ok / ts_ok  output  1 each  comparison results, held until the next accepted start.
REQ-014 timeout  output  1  sticky flag: the last check aborted on a waitrequest timeout.
REQ-015 id_value / ts_value  output  32 each  captured readdata for addresses 0 and 1.

Function
REQ-016 The FSM SHALL use states IDLE, RD_ID, RD_TS, FINISH.
REQ-017 IDLE: start=1 SHALL move the FSM to RD_ID and clear id_ok, ts_ok, timeout, id_value and ts_value on the same edge.
REQ-018 RD_ID SHALL drive avm_read=1 and avm_address=0, both stable until completion.
REQ-019 On RD_ID completion, avm_readdata SHALL be captured into id_value, id_ok SHALL be set to (avm_readdata==EXPECTED_ID), and the FSM SHALL go to RD_TS.
REQ-020 RD_TS SHALL drive avm_read=1 and avm_address=1; on completion, the data SHALL be captured into ts_value, ts_ok SHALL be set to (avm_readdata==EXPECTED_TS), and the FSM SHALL go to FINISH.
REQ-021 FINISH SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-022 avm_read SHALL be 0 in IDLE and FINISH, and SHALL never be high for two back-to-back transfers without an intervening address change.
REQ-023 The wait counter SHALL be 16 bits, clear at each read start and at each completion, and increment on each cycle with avm_read=1 and avm_waitrequest=1.
REQ-024 If the wait counter reaches TIMEOUT_CYCLES while waitrequest is still high, the FSM SHALL set timeout, leave the unfinished result flag at 0, drop avm_read, and go to FINISH.
REQ-025 A completion on the same cycle that the counter reaches TIMEOUT_CYCLES SHALL count as a completion, not a timeout.
REQ-026 start while busy SHALL be ignored.
REQ-027 With waitrequest held at 0, done SHALL occur 4 cycles after the accepted start edge: RD_ID, RD_TS, FINISH, then the pulse visible in FINISH.

Reset
REQ-028 Reset SHALL force IDLE, clear the counter, and drive all outputs to 0: avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, id_value and ts_value.
REQ-029 Reset mid-read SHALL drop avm_read immediately (asynchronously), and no done SHALL follow.

Structure
REQ-030 The FSM state encoding, address constants (ADDR_ID=0, ADDR_TS=1) and the counter width SHALL live in a shared package, de2_115_sysid_pkg.
REQ-031 The wait counter SHALL be one sub-module, de2_115_wait_timer, with clear, enable and terminal-count ports.

Verification
REQ-032 waitrequest=0, slave returns 0 at address 0 and 1523842120 at address 1; pulse start -> done 4 cycles later, id_ok=1, ts_ok=1, timeout=0.
REQ-033 Slave returns 1523842121 at address 1 -> ts_ok=0, id_ok=1, ts_value=1523842121.
REQ-034 waitrequest high for 3 cycles on each read, TIMEOUT_CYCLES=255 -> done at cycle 10, both ok flags set, avm_address stable during the stalls.
REQ-035 waitrequest stuck high, TIMEOUT_CYCLES=8 -> timeout=1 and done after 8 stall cycles in RD_ID, id_ok=0, ts_ok=0, address 1 never driven.
REQ-036 start pulsed again during RD_TS -> ignored, only one done; reset asserted in RD_ID -> avm_read=0 at once, no done, all outputs 0.

Source files
------------

// File: rtl/de2_115_sysid_pkg.sv
// Shared definitions for the DE2-115 sysid checker: FSM states, sysid word
// addresses and the width of the waitrequest timer.
package de2_115_sysid_pkg;

  localparam int   CNT_W   = 16;
  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/de2_115_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sysid slave.
// Handshake: the master raises avm_read with a stable avm_address and holds
// both until a cycle where avm_waitrequest is low; that cycle completes the
// transfer and avm_readdata is valid on it (zero read latency).
interface de2_115_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (output avm_address, output avm_read,
                  input  avm_waitrequest, input avm_readdata);
  modport slave  (input  avm_address, input avm_read,
                  output avm_waitrequest, output avm_readdata);
endinterface

// File: rtl/de2_115_wait_timer.sv
// Counts consecutive stalled read cycles; terminal flags the stall cycle on
// which the count reaches TIMEOUT_CYCLES.
module de2_115_wait_timer
  import de2_115_sysid_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Stall counter: clear wins over increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  // This stall cycle is the one that brings the count up to the limit.
  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/de2_115_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them
// against the expected build values, with a per-read waitrequest timeout.
module de2_115_sysid_checker
  import de2_115_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1523842120,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  de2_115_sysid_checker_if.master        avm,
  output logic                           busy,
  output logic                           done,
  output logic                           id_ok,
  output logic                           ts_ok,
  output logic                           timeout,
  output logic [31:0]                    id_value,
  output logic [31:0]                    ts_value,
  output state_t                         state_dbg
);

  state_t state;
  logic   xfer_done;
  logic   stall;
  logic   in_read;
  logic   timer_term;

  assign xfer_done = avm.avm_read && !avm.avm_waitrequest;
  assign stall     = avm.avm_read &&  avm.avm_waitrequest;
  assign in_read   = (state == RD_ID) || (state == RD_TS);
  assign state_dbg = state;

  // Counter sits at zero outside the read states and restarts per transfer.
  de2_115_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (!in_read || xfer_done),
    .enable   (stall),
    .terminal (timer_term)
  );

  // Check sequencer: ID read, timestamp read, one-cycle done report.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      avm.avm_read    <= 1'b0;
      avm.avm_address <= ADDR_ID;
      busy            <= 1'b0;
      done            <= 1'b0;
      id_ok           <= 1'b0;
      ts_ok           <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= RD_ID;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= ADDR_ID;
            busy            <= 1'b1;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout         <= 1'b0;
            id_value        <= '0;
            ts_value        <= '0;
          end
        end
        RD_ID: begin
          if (xfer_done) begin
            id_value        <= avm.avm_readdata;
            id_ok           <= (avm.avm_readdata == EXPECTED_ID);
            avm.avm_address <= ADDR_TS;
            state           <= RD_TS;
          end else if (timer_term) begin
            timeout      <= 1'b1;
            avm.avm_read <= 1'b0;
            state        <= FINISH;
          end
        end
        RD_TS: begin
          if (xfer_done) begin
            ts_value     <= avm.avm_readdata;
            ts_ok        <= (avm.avm_readdata == EXPECTED_TS);
            avm.avm_read <= 1'b0;
            state        <= FINISH;
          end else if (timer_term) begin
            timeout      <= 1'b1;
            avm.avm_read <= 1'b0;
            state        <= FINISH;
          end
        end
        FINISH: begin
          done            <= 1'b1;
          busy            <= 1'b0;
          avm.avm_address <= ADDR_ID;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
